// File: rtl/reg_file_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving the 16x8 register file and ALU.
// All outputs are registered; one instruction retires per fetch/decode/execute/writeback pass.
module reg_file_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [3:0]         RA1,
  output logic [3:0]         RA2,
  output logic [3:0]         WA,
  output logic               write_enable,
  output logic [2:0]         alu_op,
  output logic               imm_sel,
  output logic [7:0]         imm,
  output logic               busy,
  output logic               halted
);

  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      op_q, op_d;
  logic [3:0]      rd_q, rd_d;

  logic            req_d;
  logic            we_d;
  logic [3:0]      ra1_d, ra2_d, wa_d;
  logic [2:0]      alu_d;
  logic            isel_d;
  logic [7:0]      imm_d;
  logic            busy_d, halted_d;

  function automatic logic is_write(input logic [3:0] op);
    return (op >= 4'h1) && (op <= OP_MOV);
  endfunction

  // ALU encoding: ADD..XOR map to 0..4, LDI passes B, MOV passes A.
  function automatic logic [2:0] alu_decode(input logic [3:0] op);
    logic [2:0] f;
    f = 3'd0;
    if ((op >= 4'h1) && (op <= 4'h5)) begin
      f = 3'(op - 4'h1);
    end else if (op == OP_LDI) begin
      f = 3'd5;
    end else if (op == OP_MOV) begin
      f = 3'd6;
    end
    return f;
  endfunction

  assign instr_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    rd_d    = rd_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    ra1_d   = RA1;
    ra2_d   = RA2;
    wa_d    = WA;
    alu_d   = alu_op;
    isel_d  = imm_sel;
    imm_d   = imm;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      end
      S_FETCH: begin
        req_d = 1'b1;
        // Decode fields are captured straight from the accepted word so they
        // are already valid during DECODE.
        if (instr_req && instr_valid) begin
          state_d = S_DECODE;
          req_d   = 1'b0;
          pc_d    = pc_q + PC_W'(1);
          op_d    = instr_data[15:12];
          rd_d    = instr_data[11:8];
          ra1_d   = instr_data[7:4];
          ra2_d   = instr_data[3:0];
          alu_d   = alu_decode(instr_data[15:12]);
          isel_d  = (instr_data[15:12] == OP_LDI);
          imm_d   = (instr_data[15:12] == OP_LDI) ? instr_data[7:0] : 8'h00;
        end
      end
      S_DECODE: begin
        state_d = (op_q == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        if (is_write(op_q)) begin
          we_d = 1'b1;
          wa_d = rd_q;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // Everything resets asynchronously so write_enable drops with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      op_q         <= 4'h0;
      rd_q         <= 4'h0;
      instr_req    <= 1'b0;
      write_enable <= 1'b0;
      RA1          <= 4'h0;
      RA2          <= 4'h0;
      WA           <= 4'h0;
      alu_op       <= 3'd0;
      imm_sel      <= 1'b0;
      imm          <= 8'h00;
      busy         <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      instr_req    <= req_d;
      write_enable <= we_d;
      RA1          <= ra1_d;
      RA2          <= ra2_d;
      WA           <= wa_d;
      alu_op       <= alu_d;
      imm_sel      <= isel_d;
      imm          <= imm_d;
      busy         <= busy_d;
      halted       <= halted_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench for reg_file_sequencer: table of decoded instructions, hand-written corner
// sequences (stall, halt, async reset in WB) and a randomized run against a reference model.
module tb_reg_file_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable;
  logic [2:0]  alu_op;
  logic        imm_sel;
  logic [7:0]  imm;
  logic        busy, halted;

  logic [15:0] imem [256];

  assign instr_data = imem[instr_addr];

  reg_file_sequencer #(.PC_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .RA1(RA1), .RA2(RA2), .WA(WA), .write_enable(write_enable),
    .alu_op(alu_op), .imm_sel(imm_sel), .imm(imm),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [2:0]  alu;
    logic        isel;
    logic [7:0]  imm;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic [15:0] instr, input logic we, input logic [3:0] wa,
                               input logic [3:0] ra1, input logic [3:0] ra2, input logic [2:0] alu,
                               input logic isel, input logic [7:0] immv);
    vec_t v;
    v.instr = instr; v.we = we; v.wa = wa; v.ra1 = ra1; v.ra2 = ra2;
    v.alu = alu; v.isel = isel; v.imm = immv;
    return v;
  endfunction

  // Reference: what the instruction set says each word must do.
  function automatic vec_t model(input logic [15:0] w);
    vec_t r;
    logic [3:0] op;
    op = w[15:12];
    r = '0;
    r.instr = w; r.wa = w[11:8]; r.ra1 = w[7:4]; r.ra2 = w[3:0];
    if (op >= 4'd1 && op <= 4'd5) begin
      r.we = 1'b1; r.alu = 3'(op - 4'd1);
    end else if (op == 4'd6) begin
      r.we = 1'b1; r.alu = 3'd5; r.isel = 1'b1; r.imm = w[7:0];
    end else if (op == 4'd7) begin
      r.we = 1'b1; r.alu = 3'd6;
    end
    return r;
  endfunction

  // Transaction monitor for the randomized run.
  logic mon_en = 1'b0;
  int   mpc = 0;
  int   n_acc = 0;
  vec_t pend = '0;
  logic pend_v = 1'b0;
  logic pend_done = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      mpc = 0; n_acc = 0; pend = '0; pend_v = 1'b0; pend_done = 1'b0;
    end else begin
      check("rnd_not_halted", 32'(halted), 32'(0));
      if (write_enable) begin
        check("rnd_we_allowed", 32'({pend_v, pend.we, pend_done}), 32'(3'b110));
        check("rnd_wa", 32'(WA), 32'(pend.wa));
        check("rnd_ra1", 32'(RA1), 32'(pend.ra1));
        check("rnd_ra2", 32'(RA2), 32'(pend.ra2));
        check("rnd_alu", 32'(alu_op), 32'(pend.alu));
        check("rnd_isel", 32'(imm_sel), 32'(pend.isel));
        check("rnd_imm", 32'(imm), 32'(pend.imm));
        pend_done = 1'b1;
      end
      if (instr_req && instr_valid) begin
        if (pend_v) check("rnd_write_count", 32'(pend_done), 32'(pend.we));
        check("rnd_fetch_addr", 32'(instr_addr), 32'(mpc[7:0]));
        pend = model(imem[mpc[7:0]]);
        pend_v = 1'b1;
        pend_done = 1'b0;
        mpc = (mpc + 1) % 256;
        n_acc++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge in FETCH; leaves the bench at the WB negedge.
  task automatic run_vec(input vec_t v, input logic [7:0] pc, output int waited);
    waited = 0;
    while (!(instr_req && instr_valid) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_seen", 32'(instr_req && instr_valid), 32'(1));
    check("fetch_addr", 32'(instr_addr), 32'(pc));
    @(negedge clk);
    check("dec_ra1", 32'(RA1), 32'(v.ra1));
    check("dec_ra2", 32'(RA2), 32'(v.ra2));
    check("dec_req", 32'(instr_req), 32'(0));
    check("dec_addr", 32'(instr_addr), 32'(8'(pc + 8'd1)));
    check("dec_we", 32'(write_enable), 32'(0));
    check("dec_busy", 32'(busy), 32'(1));
    if (v.we) begin
      check("dec_alu", 32'(alu_op), 32'(v.alu));
      check("dec_isel", 32'(imm_sel), 32'(v.isel));
      check("dec_imm", 32'(imm), 32'(v.imm));
    end
    @(negedge clk);
    check("exec_we", 32'(write_enable), 32'(0));
    @(negedge clk);
    check("wb_we", 32'(write_enable), 32'(v.we));
    if (v.we) begin
      check("wb_wa", 32'(WA), 32'(v.wa));
      check("wb_ra1", 32'(RA1), 32'(v.ra1));
      check("wb_ra2", 32'(RA2), 32'(v.ra2));
      check("wb_alu", 32'(alu_op), 32'(v.alu));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(instr_req), 32'(0));
    check({tag, "_we"}, 32'(write_enable), 32'(0));
    check({tag, "_addr"}, 32'(instr_addr), 32'(0));
    check({tag, "_ra"}, 32'({RA1, RA2, WA}), 32'(0));
    check({tag, "_alu"}, 32'({alu_op, imm_sel, imm}), 32'(0));
    check({tag, "_flags"}, 32'({busy, halted}), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt [11];

  initial begin
    int w;
    vt[0]  = mkv(16'h6105, 1'b1, 4'h1, 4'h0, 4'h5, 3'd5, 1'b1, 8'h05);
    vt[1]  = mkv(16'h6107, 1'b1, 4'h1, 4'h0, 4'h7, 3'd5, 1'b1, 8'h07);
    vt[2]  = mkv(16'h6206, 1'b1, 4'h2, 4'h0, 4'h6, 3'd5, 1'b1, 8'h06);
    vt[3]  = mkv(16'h1512, 1'b1, 4'h5, 4'h1, 4'h2, 3'd0, 1'b0, 8'h00);
    vt[4]  = mkv(16'h9abc, 1'b0, 4'ha, 4'hb, 4'hc, 3'd0, 1'b0, 8'h00);
    vt[5]  = mkv(16'h0000, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, 8'h00);
    vt[6]  = mkv(16'h2f34, 1'b1, 4'hf, 4'h3, 4'h4, 3'd1, 1'b0, 8'h00);
    vt[7]  = mkv(16'h3a12, 1'b1, 4'ha, 4'h1, 4'h2, 3'd2, 1'b0, 8'h00);
    vt[8]  = mkv(16'h4b21, 1'b1, 4'hb, 4'h2, 4'h1, 3'd3, 1'b0, 8'h00);
    vt[9]  = mkv(16'h5c77, 1'b1, 4'hc, 4'h7, 4'h7, 3'd4, 1'b0, 8'h00);
    vt[10] = mkv(16'h7d90, 1'b1, 4'hd, 4'h9, 4'h0, 3'd6, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 11; i++) imem[i] = vt[i].instr;
    imem[11] = 16'h6133;
    imem[12] = 16'hF000;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));

    // Table: one instruction per pass, accepted back-to-back every 4 cycles.
    instr_valid = 1'b1;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      run_vec(vt[i], 8'(i), w);
      check("latency_4", 32'(w), 32'(0));
    end

    // Fetch stall: valid low for 5 cycles holds the request and PC.
    instr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_req", 32'(instr_req), 32'(1));
      check("stall_addr", 32'(instr_addr), 32'(11));
      check("stall_we", 32'(write_enable), 32'(0));
      check("stall_busy", 32'(busy), 32'(1));
    end
    instr_valid = 1'b1;
    run_vec(mkv(16'h6133, 1'b1, 4'h1, 4'h3, 4'h3, 3'd5, 1'b1, 8'h33), 8'd11, w);
    check("stall_release", 32'(w), 32'(0));

    // HALT is sticky and ignores start and valid.
    @(negedge clk);
    check("halt_fetch_addr", 32'(instr_addr), 32'(12));
    @(negedge clk);
    @(negedge clk);
    check("halt_flag", 32'(halted), 32'(1));
    check("halt_busy", 32'(busy), 32'(0));
    check("halt_req", 32'(instr_req), 32'(0));
    check("halt_we", 32'(write_enable), 32'(0));
    pulse_start();
    repeat (4) @(negedge clk);
    check("halt_sticky", 32'(halted), 32'(1));
    check("halt_sticky_req", 32'(instr_req), 32'(0));
    check("halt_sticky_addr", 32'(instr_addr), 32'(13));
    rst_n = 1'b0;
    #1 check_reset_outputs("halt_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_req", 32'(instr_req), 32'(0));
    check("post_rst_idle_busy", 32'(busy), 32'(0));

    // Async reset in the middle of WB: write strobe must vanish before the next edge.
    pulse_start();
    run_vec(vt[0], 8'd0, w);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midwb_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized run (no HALT) with random fetch stalls; crosses the PC wrap.
    for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    mon_en = 1'b1;
    instr_valid = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int c = 0; c < 8000 && n_acc < 300; c++) begin
      @(posedge clk);
      #1 instr_valid = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    check("rnd_accept_count", 32'(n_acc >= 300), 32'(1));
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
